// File: rtl/prom_fetch_ctrl_if.sv
// prom_fetch_ctrl_if: button, ROM and display signals of the program-ROM fetch controller
//   master: controller side (drives the ROM address/enable and the display pair)
//   slave:  environment side (buttons, auto enable, ROM data; observes the rest)
interface prom_fetch_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic              i_button_inc;
  logic              i_button_dec;
  logic              i_auto_en;
  logic [ADDR_W-1:0] o_rom_addr;
  logic              o_rom_ce;
  logic [DATA_W-1:0] i_rom_dout;
  logic [ADDR_W-1:0] o_addr;
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              o_busy;
  modport master (
    input  i_button_inc, i_button_dec, i_auto_en, i_rom_dout,
    output o_rom_addr, o_rom_ce, o_addr, o_data, o_valid, o_busy
  );
  modport slave (
    output i_button_inc, i_button_dec, i_auto_en, i_rom_dout,
    input  o_rom_addr, o_rom_ce, o_addr, o_data, o_valid, o_busy
  );
endinterface

// File: rtl/prom_fetch_ctrl.sv
// prom_fetch_ctrl: sequences program-ROM reads and presents a coherent {address, data} pair
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus (master) : buttons/auto enable in, ROM address/enable out, ROM data in,
//                  o_addr/o_data/o_valid display pair out, o_busy out
//   AUTO_STEP_EN : when defined, builds the auto-step period timer driven by i_auto_en
module prom_fetch_ctrl #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1,
  parameter int FREQ    = 27_000_000,
  parameter int STEP_MS = 250
) (
  input logic i_clk,
  input logic i_rst,
  prom_fetch_ctrl_if.master bus
);
  typedef enum logic [2:0] {BOOT, IDLE, ISSUE, WAIT, CAPTURE} state_t;
  state_t state;
  logic [2:0] inc_s, dec_s;
  logic inc_e, dec_e, btn_req, step, go, go_inc, pend_v, pend_inc;
  logic [1:0] wcnt;
  logic [ADDR_W-1:0] target;
  assign inc_e = inc_s[1] & ~inc_s[2];
  assign dec_e = dec_s[1] & ~dec_s[2];
  // simultaneous inc and dec cancel out
  assign btn_req = inc_e ^ dec_e;
  // a fresh button beats the pending slot, which beats the auto step
  assign go = btn_req | pend_v | step;
  assign go_inc = btn_req ? inc_e : pend_v ? pend_inc : 1'b1;
  assign target = go_inc ? bus.o_addr + 1'b1 : bus.o_addr - 1'b1;
`ifdef AUTO_STEP_EN
  localparam int PERIOD = FREQ / 1000 * STEP_MS;
  localparam int TW = PERIOD > 1 ? $clog2(PERIOD) : 1;
  logic [TW-1:0] tmr;
  assign step = bus.i_auto_en && tmr == TW'(PERIOD - 1);
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) tmr <= '0;
    else tmr <= (!bus.i_auto_en || btn_req || step) ? '0 : tmr + 1'b1;
`else
  logic unused_auto;
  assign unused_auto = ^{bus.i_auto_en, FREQ[0], STEP_MS[0]};
  assign step = 1'b0;
`endif
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      inc_s <= '0;
      dec_s <= '0;
    end else begin
      inc_s <= {inc_s[1:0], bus.i_button_inc};
      dec_s <= {dec_s[1:0], bus.i_button_dec};
    end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state          <= BOOT;
      pend_v         <= 1'b0;
      pend_inc       <= 1'b0;
      wcnt           <= '0;
      bus.o_rom_addr <= '0;
      bus.o_rom_ce   <= 1'b0;
      bus.o_addr     <= '0;
      bus.o_data     <= '0;
      bus.o_valid    <= 1'b0;
      bus.o_busy     <= 1'b0;
    end else begin
      bus.o_rom_ce <= 1'b0;
      bus.o_valid  <= 1'b0;
      if (state != IDLE && btn_req) begin
        pend_v   <= 1'b1;
        pend_inc <= inc_e;
      end
      case (state)
        BOOT: begin
          bus.o_rom_addr <= '0;
          bus.o_rom_ce   <= 1'b1;
          bus.o_busy     <= 1'b1;
          state          <= ISSUE;
        end
        IDLE: if (go) begin
          pend_v         <= 1'b0;
          bus.o_rom_addr <= target;
          bus.o_rom_ce   <= 1'b1;
          bus.o_busy     <= 1'b1;
          state          <= ISSUE;
        end
        ISSUE: begin
          wcnt  <= '0;
          state <= WAIT;
        end
        // data is captured on the last WAIT edge so o_valid and the pair appear together
        WAIT: if (wcnt == 2'(ROM_LAT - 1)) begin
          bus.o_data  <= bus.i_rom_dout;
          bus.o_addr  <= bus.o_rom_addr;
          bus.o_valid <= 1'b1;
          state       <= CAPTURE;
        end else wcnt <= wcnt + 1'b1;
        CAPTURE: begin
          bus.o_busy <= 1'b0;
          state      <= IDLE;
        end
        default: state <= BOOT;
      endcase
    end
endmodule

// File: tb/tb_prom_fetch_ctrl.sv
// tb_prom_fetch_ctrl: scoreboard bench for prom_fetch_ctrl with a latency-1 ROM model
module tb_prom_fetch_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  int ce_cnt = 0;
  logic [11:0] last_ce = '0;
  logic [19:0] exp_q[$];
  logic [7:0] rom [4096];
  prom_fetch_ctrl_if #(.ADDR_W(12), .DATA_W(8)) bus ();
  prom_fetch_ctrl #(.ADDR_W(12), .DATA_W(8), .ROM_LAT(1)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.o_rom_ce) bus.i_rom_dout <= rom[bus.o_rom_addr];
  function automatic logic [7:0] rom_byte(input logic [11:0] a);
    return a == 12'h000 ? 8'h3C : a == 12'h001 ? 8'hA5 : a == 12'hFFF ? 8'hC3 : a[7:0] ^ 8'h5A;
  endfunction
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  always @(negedge clk) if (!rst) begin
    if (bus.o_rom_ce) begin
      ce_cnt++;
      last_ce = bus.o_rom_addr;
    end
    if (bus.o_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_valid: got addr %0h data %0h expected no output", bus.o_addr, bus.o_data);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        check("valid_addr", 32'(bus.o_addr), 32'(e[19:8]));
        check("valid_data", 32'(bus.o_data), 32'(e[7:0]));
      end
    end
  end
  task automatic wait_valid(input int limit, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.o_valid && lat < limit);
    if (!bus.o_valid) begin
      tests++;
      fails++;
      $display("FAIL valid_timeout: got no o_valid expected one within %0d cycles", limit);
    end
  endtask
  task automatic press(input bit inc, input bit dec, input logic [11:0] a);
    int lat;
    exp_q.push_back({a, rom_byte(a)});
    bus.i_button_inc = inc;
    bus.i_button_dec = dec;
    wait_valid(20, lat);
    bus.i_button_inc = 1'b0;
    bus.i_button_dec = 1'b0;
    repeat (4) @(negedge clk);
  endtask
  task automatic wait_ce(input int limit);
    int n;
    n = 0;
    while (!bus.o_rom_ce && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!bus.o_rom_ce) begin
      tests++;
      fails++;
      $display("FAIL ce_timeout: got no o_rom_ce expected one within %0d cycles", limit);
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected one before 500000 time units");
    $fatal(1, "watchdog expired");
  end
  initial begin
    int lat, ce0;
    for (int i = 0; i < 4096; i++) rom[i] = rom_byte(12'(i));
    bus.i_button_inc = 1'b0;
    bus.i_button_dec = 1'b0;
    bus.i_auto_en = 1'b1;
    bus.i_rom_dout = '0;
    repeat (3) @(negedge clk);
    check("rst_rom_addr", 32'(bus.o_rom_addr), 0);
    check("rst_rom_ce", 32'(bus.o_rom_ce), 0);
    check("rst_addr", 32'(bus.o_addr), 0);
    check("rst_data", 32'(bus.o_data), 0);
    check("rst_valid", 32'(bus.o_valid), 0);
    check("rst_busy", 32'(bus.o_busy), 0);
    // boot fetch of address 0
    exp_q.push_back({12'h000, 8'h3C});
    rst = 1'b0;
    wait_valid(10, lat);
    check("boot_latency", 32'(lat), 3);
    check("boot_reads", 32'(ce_cnt), 1);
    check("boot_ce_addr", 32'(last_ce), 32'h000);
    @(negedge clk);
    check("boot_busy_low", 32'(bus.o_busy), 0);
    repeat (3) @(negedge clk);
    // inc: two sync flops, then ISSUE, WAIT, CAPTURE -> valid 5 cycles after the raw press
    exp_q.push_back({12'h001, 8'hA5});
    bus.i_button_inc = 1'b1;
    wait_valid(20, lat);
    check("inc_latency", 32'(lat), 5);
    ce0 = ce_cnt;
    repeat (1000) @(negedge clk);
    check("hold_no_repeat", 32'(ce_cnt - ce0), 0);
    check("hold_addr", 32'(bus.o_addr), 32'h001);
    bus.i_button_inc = 1'b0;
    repeat (4) @(negedge clk);
    // wrap-around in both directions
    press(1'b0, 1'b1, 12'h000);
    press(1'b0, 1'b1, 12'hFFF);
    press(1'b1, 1'b0, 12'h000);
    // simultaneous inc and dec cancel
    ce0 = ce_cnt;
    bus.i_button_inc = 1'b1;
    bus.i_button_dec = 1'b1;
    repeat (10) @(negedge clk);
    check("both_no_read", 32'(ce_cnt - ce0), 0);
    check("both_addr", 32'(bus.o_addr), 32'h000);
    bus.i_button_inc = 1'b0;
    bus.i_button_dec = 1'b0;
    repeat (4) @(negedge clk);
    // dec pressed during the WAIT of an inc read
    exp_q.push_back({12'h001, 8'hA5});
    exp_q.push_back({12'h000, 8'h3C});
    bus.i_button_inc = 1'b1;
    wait_ce(20);
    @(negedge clk);
    check("wait_busy", 32'(bus.o_busy), 1);
    bus.i_button_inc = 1'b0;
    bus.i_button_dec = 1'b1;
    wait_valid(20, lat);
    wait_valid(20, lat);
    bus.i_button_dec = 1'b0;
    repeat (4) @(negedge clk);
    // walk up to 0x00F, then abandon the read of 0x010 with reset
    for (int i = 1; i < 16; i++) press(1'b1, 1'b0, 12'(i));
    bus.i_button_inc = 1'b1;
    wait_ce(20);
    @(negedge clk);
    check("abort_ce_addr", 32'(last_ce), 32'h010);
    rst = 1'b1;
    #1;
    check("abort_rom_addr", 32'(bus.o_rom_addr), 0);
    check("abort_addr", 32'(bus.o_addr), 0);
    check("abort_data", 32'(bus.o_data), 0);
    check("abort_busy", 32'(bus.o_busy), 0);
    bus.i_button_inc = 1'b0;
    repeat (3) @(negedge clk);
    ce0 = ce_cnt;
    exp_q.push_back({12'h000, 8'h3C});
    rst = 1'b0;
    wait_valid(10, lat);
    // auto_en stays high: without the timer nothing beyond the boot fetch is read
    repeat (60) @(negedge clk);
    check("reboot_reads", 32'(ce_cnt - ce0), 1);
    check("reboot_ce_addr", 32'(last_ce), 32'h000);
    check("reboot_addr", 32'(bus.o_addr), 32'h000);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
